// File: rtl/cp0_regs.sv
// cp0_regs: architectural CP0 register file (BadVAddr, Count, Compare, Status, Cause, EPC).
//
// Ports:
//   clk, rst                 clock (rising edge) and asynchronous active-low reset
//   cp0_write_en/addr/data   MTC0 write from WB, address = {rd[4:0], sel[2:0]}
//   cp0_read_addr            MFC0 source address for cp0_read_data_o
//   int_i                    external level-sensitive interrupt lines
//   exc_en, exc_eret         exception / ERET commit from MEM
//   exc_code, exc_pc, exc_bd, exc_badvaddr  details of the committing exception
//   cp0_*_o                  combinational views of the registers
//   cp0_read_data_o          register selected by cp0_read_addr, 0 when unmapped
//   timer_int_o              Cause.TI
//
// Updates land one edge after they are presented; there is no internal bypass, the downstream
// forwarding stage overlays in-flight MEM/WB writes on the Count/Status/Cause/EPC taps.
module cp0_regs (
  input  logic        clk,
  input  logic        rst,
  input  logic        cp0_write_en,
  input  logic [7:0]  cp0_write_addr,
  input  logic [31:0] cp0_write_data,
  input  logic [7:0]  cp0_read_addr,
  input  logic [5:0]  int_i,
  input  logic        exc_en,
  input  logic        exc_eret,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        exc_bd,
  input  logic [31:0] exc_badvaddr,
  output logic [31:0] cp0_count_o,
  output logic [31:0] cp0_status_o,
  output logic [31:0] cp0_cause_o,
  output logic [31:0] cp0_epc_o,
  output logic [31:0] cp0_badvaddr_o,
  output logic [31:0] cp0_read_data_o,
  output logic        timer_int_o
);

  localparam logic [7:0] AddrBadVAddr = 8'h40;
  localparam logic [7:0] AddrCount    = 8'h48;
  localparam logic [7:0] AddrCompare  = 8'h58;
  localparam logic [7:0] AddrStatus   = 8'h60;
  localparam logic [7:0] AddrCause    = 8'h68;
  localparam logic [7:0] AddrEpc      = 8'h70;

  localparam logic [4:0] ExcAdEL = 5'd4;
  localparam logic [4:0] ExcAdES = 5'd5;

  // Register state
  logic [31:0] count_q, count_d;
  logic        tick_q, tick_d;
  logic [31:0] compare_q, compare_d;
  logic [31:0] badvaddr_q, badvaddr_d;
  logic [31:0] epc_q, epc_d;
  logic [7:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [1:0]  ip_sw_q, ip_sw_d;
  logic [5:0]  ip_hw_q;
  logic        ti_q, ti_d;

  // MTC0 decode. Count/Compare writes always land; the others yield to exception/ERET commit.
  logic wr_count, wr_compare, wr_arch;
  logic wr_status, wr_cause, wr_epc, wr_badvaddr;
  logic timer_match;

  always_comb begin
    wr_count    = cp0_write_en && (cp0_write_addr == AddrCount);
    wr_compare  = cp0_write_en && (cp0_write_addr == AddrCompare);
    wr_arch     = cp0_write_en && !exc_en && !exc_eret;
    wr_status   = wr_arch && (cp0_write_addr == AddrStatus);
    wr_cause    = wr_arch && (cp0_write_addr == AddrCause);
    wr_epc      = wr_arch && (cp0_write_addr == AddrEpc);
    wr_badvaddr = wr_arch && (cp0_write_addr == AddrBadVAddr);
    timer_match = (count_q == compare_q) && (compare_q != 32'd0);
  end

  // Timer: Count advances every other cycle; a Compare write clears TI even on a match cycle.
  always_comb begin
    tick_d    = ~tick_q;
    count_d   = tick_q ? count_q + 32'd1 : count_q;
    compare_d = compare_q;
    ti_d      = ti_q | timer_match;
    if (wr_count) begin
      count_d = cp0_write_data;
      tick_d  = 1'b0;
    end
    if (wr_compare) begin
      compare_d = cp0_write_data;
      ti_d      = 1'b0;
    end
  end

  // Status/Cause/EPC/BadVAddr: exception commit > ERET > MTC0.
  always_comb begin
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    exc_code_d = exc_code_q;
    ip_sw_d    = ip_sw_q;

    if (exc_en) begin
      // Nested exceptions (EXL already set) keep the original EPC and BD.
      if (!exl_q) begin
        epc_d = exc_bd ? exc_pc - 32'd4 : exc_pc;
        bd_d  = exc_bd;
      end
      exl_d      = 1'b1;
      exc_code_d = exc_code;
      if ((exc_code == ExcAdEL) || (exc_code == ExcAdES)) begin
        badvaddr_d = exc_badvaddr;
      end
    end else if (exc_eret) begin
      exl_d = 1'b0;
    end else begin
      if (wr_status) begin
        im_d  = cp0_write_data[15:8];
        exl_d = cp0_write_data[1];
        ie_d  = cp0_write_data[0];
      end
      if (wr_cause) begin
        ip_sw_d = cp0_write_data[9:8];
      end
      if (wr_epc) begin
        epc_d = cp0_write_data;
      end
      if (wr_badvaddr) begin
        badvaddr_d = cp0_write_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q    <= 32'd0;
      tick_q     <= 1'b0;
      compare_q  <= 32'd0;
      badvaddr_q <= 32'd0;
      epc_q      <= 32'd0;
      im_q       <= 8'd0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      exc_code_q <= 5'd0;
      ip_sw_q    <= 2'd0;
      ip_hw_q    <= 6'd0;
      ti_q       <= 1'b0;
    end else begin
      count_q    <= count_d;
      tick_q     <= tick_d;
      compare_q  <= compare_d;
      badvaddr_q <= badvaddr_d;
      epc_q      <= epc_d;
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      exc_code_q <= exc_code_d;
      ip_sw_q    <= ip_sw_d;
      ip_hw_q    <= int_i;
      ti_q       <= ti_d;
    end
  end

  // Architectural views. BEV (bit 22) is hard-wired to 1; IP7 shares the timer interrupt.
  always_comb begin
    cp0_count_o    = count_q;
    cp0_epc_o      = epc_q;
    cp0_badvaddr_o = badvaddr_q;
    timer_int_o    = ti_q;
    cp0_status_o   = {9'd0, 1'b1, 6'd0, im_q, 6'd0, exl_q, ie_q};
    cp0_cause_o    = {bd_q, ti_q, 14'd0, ip_hw_q[5] | ti_q, ip_hw_q[4:0], ip_sw_q, 1'b0,
                      exc_code_q, 2'b00};
  end

  always_comb begin
    cp0_read_data_o = 32'd0;
    case (cp0_read_addr)
      AddrBadVAddr: cp0_read_data_o = badvaddr_q;
      AddrCount:    cp0_read_data_o = count_q;
      AddrCompare:  cp0_read_data_o = compare_q;
      AddrStatus:   cp0_read_data_o = cp0_status_o;
      AddrCause:    cp0_read_data_o = cp0_cause_o;
      AddrEpc:      cp0_read_data_o = epc_q;
      default:      cp0_read_data_o = 32'd0;
    endcase
  end

endmodule
